// File: rtl/sine_sched_pkg.sv
// Shared types and constants for the sine sample scheduler: table geometry,
// sample width, FSM states, dither LFSR constants and index arithmetic.
package sine_sched_pkg;

  localparam int TABLE_LEN = 40;
  localparam int DATA_W    = 24;
  localparam int IDX_W     = 6;

  // Fibonacci LFSR: taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FETCH
  } state_t;

  // A step that would skip past the whole table degrades to a plain walk.
  function automatic logic [IDX_W-1:0] eff_step(input logic [5:0] step_cfg);
    return (step_cfg >= IDX_W'(TABLE_LEN)) ? IDX_W'(1) : step_cfg;
  endfunction

  // (idx + step) mod TABLE_LEN; both operands are below TABLE_LEN.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] step);
    logic [IDX_W:0] sum;
    sum = {1'b0, idx} + {1'b0, step};
    if (sum >= (IDX_W+1)'(TABLE_LEN)) sum = sum - (IDX_W+1)'(TABLE_LEN);
    return sum[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/sine_table_rom.sv
// 40-entry, 24-bit sine table (amplitude 2500000, 9 degrees per entry) with a
// registered read port. Only the first quarter wave is stored; the rest is
// folded out of it by symmetry.
module sine_table_rom
  import sine_sched_pkg::*;
(
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [IDX_W-1:0]         addr,
  output logic signed [DATA_W-1:0] data
);

  logic [DATA_W-1:0] rom_val;

  function automatic logic [DATA_W-1:0] quarter(input logic [3:0] k);
    case (k)
      4'd0:    return 24'd0;
      4'd1:    return 24'd391086;
      4'd2:    return 24'd772542;
      4'd3:    return 24'd1134976;
      4'd4:    return 24'd1469463;
      4'd5:    return 24'd1767767;
      4'd6:    return 24'd2022542;
      4'd7:    return 24'd2227516;
      4'd8:    return 24'd2377641;
      4'd9:    return 24'd2469221;
      4'd10:   return 24'd2500000;
      default: return 24'd0;
    endcase
  endfunction

  // Fold the table index onto the quarter wave and restore the sign.
  // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    rom_val = '0;
    if (addr <= 6'd10)      rom_val = quarter(4'(addr));
    else if (addr <= 6'd20) rom_val = quarter(4'(6'd20 - addr));
    else if (addr <= 6'd30) rom_val = -quarter(4'(addr - 6'd20));
    else                    rom_val = -quarter(4'(6'd40 - addr));
  end

  // Registered read, enabled only for the FETCH cycle.
  // NOTE: this read register is left unreset; it is always rewritten in FETCH before anything consumes it.
  always_ff @(posedge clk) begin
    if (rd_en) data <= rom_val;
  end

endmodule

// File: rtl/sine_sample_scheduler.sv
// Sine sample scheduler: walks the sine table with a programmable tick period,
// phase step and amplitude shift, presents samples on valid/ready and counts
// samples dropped while the previous one was still pending.
// Optional feature: define SCHED_DITHER_EN to add LFSR dither (saturating)
// after the shift; without it out_data is exactly the shifted table value.
module sine_sample_scheduler
  import sine_sched_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int OVR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_cfg,
  input  logic [5:0]        step_cfg,
  input  logic [1:0]        shift_cfg,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [OVR_W-1:0]  overrun_cnt
);

  state_t                   state, state_nxt;
  logic                     start, tick;
  logic [DIV_W-1:0]         div_q, cnt;
  logic [IDX_W-1:0]         step_q, idx;
  logic [1:0]               shift_q;
  logic                     fetch_q;
  logic                     do_load;
  logic signed [DATA_W-1:0] rom_data, scaled;
  logic [DATA_W-1:0]        sample;

  sine_table_rom u_rom (
    .clk   (clk),
    .rd_en (state == FETCH),
    .addr  (idx),
    .data  (rom_data)
  );

  // Next-state logic: start from IDLE, tick out of RUN, FETCH always completes.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    tick      = 1'b0;
    case (state)
      IDLE: if (enable) begin
        state_nxt = RUN;
        start     = 1'b1;
      end
      RUN: if (!enable) begin
        state_nxt = IDLE;
      end else if (cnt >= div_q) begin
        state_nxt = FETCH;
        tick      = 1'b1;
      end
      FETCH:   state_nxt = enable ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Config capture, tick divider (counts through FETCH too) and table index.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      step_q  <= '0;
      shift_q <= '0;
      cnt     <= '0;
      idx     <= '0;
      fetch_q <= 1'b0;
    end else begin
      fetch_q <= (state == FETCH);
      if (start) begin
        div_q   <= div_cfg;
        step_q  <= eff_step(step_cfg);
        shift_q <= shift_cfg;
        cnt     <= '0;
        idx     <= '0;
      end else if (state == RUN) begin
        cnt <= tick ? '0 : cnt + DIV_W'(1);
      end else if (state == FETCH) begin
        cnt <= cnt + DIV_W'(1);
        idx <= next_idx(idx, step_q);
      end
    end
  end

  assign scaled  = rom_data >>> shift_q;
  assign do_load = fetch_q && (!out_valid || out_ready);
  assign busy    = (state != IDLE);

`ifdef SCHED_DITHER_EN
  logic [15:0]     lfsr;
  logic [4:0]      dith;
  logic [DATA_W:0] dith_sum;

  // Dither LFSR advances once per sample actually loaded.
  always_ff @(posedge clk) begin
    if (reset)        lfsr <= LFSR_SEED;
    else if (do_load) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  // Add lfsr[3:0]-8 to the shifted sample and clamp to the signed range.
  always_comb begin
    dith     = {1'b0, lfsr[3:0]} - 5'd8;
    dith_sum = {scaled[DATA_W-1], scaled} + {{(DATA_W-4){dith[4]}}, dith};
    sample   = dith_sum[DATA_W-1:0];
    if (dith_sum[DATA_W] != dith_sum[DATA_W-1])
      sample = dith_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign sample = scaled;
`endif

  // Output register and overrun counter: load when free or being accepted, else drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      overrun_cnt <= '0;
    end else if (do_load) begin
      out_data  <= sample;
      out_valid <= 1'b1;
    end else begin
      if (fetch_q && overrun_cnt != '1) overrun_cnt <= overrun_cnt + OVR_W'(1);
      if (out_valid && out_ready)       out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sine_sample_scheduler.sv
// Self-checking bench for sine_sample_scheduler: a table of configurations with
// hand-computed sample sequences, plus directed backpressure, saturation,
// disable/restart and mid-run reset sequences.
module tb_sine_sample_scheduler;
  import sine_sched_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [15:0]       div_cfg;
  logic [5:0]        step_cfg;
  logic [1:0]        shift_cfg;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [7:0]        overrun_cnt;

  always #5 clk = ~clk;

  sine_sample_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .div_cfg     (div_cfg),
    .step_cfg    (step_cfg),
    .shift_cfg   (shift_cfg),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0]       div;
    logic [5:0]        step;
    logic [1:0]        shift;
    int                lat;   // posedges after the enabling edge until out_valid
    int                per;   // clocks between samples
    logic [4:0][23:0]  exp;
  } vec_t;

  vec_t vecs [4];
  int   t [5];
  logic [23:0] d [5];
  int   n, got;

  task automatic set_vec(input int i, input logic [15:0] dv, input logic [5:0] sv,
                         input logic [1:0] hv, input int lat, input int per,
                         input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2,
                         input logic [23:0] e3, input logic [23:0] e4);
    vecs[i].div    = dv;
    vecs[i].step   = sv;
    vecs[i].shift  = hv;
    vecs[i].lat    = lat;
    vecs[i].per    = per;
    vecs[i].exp[0] = e0;
    vecs[i].exp[1] = e1;
    vecs[i].exp[2] = e2;
    vecs[i].exp[3] = e3;
    vecs[i].exp[4] = e4;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Run until `want` samples are seen (ready held by caller); times are posedge offsets from the enabling edge.
  task automatic capture(input int want, input int budget);
    n   = 0;
    got = 0;
    while (got < want && n < budget) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        t[got] = n - 1;
        d[got] = out_data;
        got++;
      end
    end
  endtask

  initial begin
    // step 1 walk; step 10 wrap 30->0; step 45 -> 1 with div 0; step 35 negative values with shift 3
    set_vec(0, 16'd4, 6'd1,  2'd0, 7, 5, 24'h000000, 24'h05F7AE, 24'h0BC9BE, 24'h115180, 24'h166C17);
    set_vec(1, 16'd2, 6'd10, 2'd2, 5, 3, 24'h000000, 24'h098968, 24'h000000, 24'hF67698, 24'h000000);
    set_vec(2, 16'd0, 6'd45, 2'd1, 3, 2, 24'h000000, 24'h02FBD7, 24'h05E4DF, 24'h08A8C0, 24'h0B360B);
    set_vec(3, 16'd1, 6'd35, 2'd3, 4, 2, 24'h000000, 24'hFCA0D5, 24'hFB3B4C, 24'hFCA0D5, 24'h000000);

    reset = 1'b1; enable = 1'b0; out_ready = 1'b1;
    div_cfg = '0; step_cfg = '0; shift_cfg = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset overrun", overrun_cnt, 0);
    check("reset out_data", out_data, 0);

    // Table-driven configurations with ready held high.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      div_cfg = vecs[v].div; step_cfg = vecs[v].step; shift_cfg = vecs[v].shift;
      enable  = 1'b1;
      capture(5, 200);
      check($sformatf("v%0d sample count", v), got, 5);
      if (got > 0) check($sformatf("v%0d latency", v), t[0], vecs[v].lat);
      for (int k = 1; k < got; k++)
        check($sformatf("v%0d period %0d", v, k), t[k] - t[k-1], vecs[v].per);
      for (int k = 0; k < got; k++)
        check($sformatf("v%0d data %0d", v, k), d[k], vecs[v].exp[k]);
      enable = 1'b0;
    end

    // Backpressure: the first sample holds while later ticks are dropped.
    do_reset();
    div_cfg = 16'd4; step_cfg = 6'd1; shift_cfg = 2'd0; out_ready = 1'b0; enable = 1'b1;
    n = 0;
    while (overrun_cnt != 8'd2 && n < 100) begin @(negedge clk); n++; end
    check("bp overrun 2", overrun_cnt, 2);
    check("bp data held", out_data, 24'h000000);
    check("bp valid held", out_valid, 1);
    n = 0;
    while (overrun_cnt != 8'd3 && n < 20) begin @(negedge clk); n++; end
    check("bp overrun 3", overrun_cnt, 3);
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 10) begin @(negedge clk); n++; end
    check("bp accepted", out_valid, 0);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("bp next valid", out_valid, 1);
    check("bp next data rom4", out_data, 24'h166C17);
    check("bp overrun kept", overrun_cnt, 3);

    // Overrun counter saturation: ~348 drops at one tick per 2 clocks.
    do_reset();
    div_cfg = 16'd0; step_cfg = 6'd1; shift_cfg = 2'd0; out_ready = 1'b0; enable = 1'b1;
    repeat (700) @(negedge clk);
    check("sat overrun", overrun_cnt, 255);
    check("sat valid", out_valid, 1);
    check("sat data", out_data, 24'h000000);

    // Disable while in RUN, then restart with an out-of-range step.
    do_reset();
    div_cfg = 16'd2; step_cfg = 6'd10; shift_cfg = 2'd0; out_ready = 1'b1; enable = 1'b1;
    @(negedge clk);
    check("dis busy in run", busy, 1);
    enable = 1'b0;
    @(negedge clk);
    check("dis busy idle", busy, 0);
    repeat (5) @(negedge clk);
    check("dis no sample", out_valid, 0);
    div_cfg = 16'd1; step_cfg = 6'd45; enable = 1'b1;
    capture(3, 100);
    check("restart count", got, 3);
    if (got > 0) check("restart latency", t[0], 4);
    for (int k = 0; k < got; k++)
      check($sformatf("restart data %0d", k), d[k],
            (k == 0) ? 32'h000000 : (k == 1) ? 32'h05F7AE : 32'h0BC9BE);
    enable = 1'b0;

    // Reset while in FETCH with a pending sample and a nonzero overrun count.
    do_reset();
    div_cfg = 16'd0; step_cfg = 6'd1; shift_cfg = 2'd0; out_ready = 1'b0; enable = 1'b1;
    repeat (6) @(negedge clk);
    check("mr busy before", busy, 1);
    check("mr valid before", out_valid, 1);
    check("mr overrun before", overrun_cnt, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mr valid", out_valid, 0);
    check("mr busy", busy, 0);
    check("mr overrun", overrun_cnt, 0);
    check("mr data", out_data, 0);
    reset = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
